// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA scan-out block.
package vga_pkg;

  // Framebuffer geometry: 160x120 pixels of 3-bit {R,G,B} colour.
  localparam logic [7:0] FB_W     = 8'd160;
  localparam logic [6:0] FB_H     = 7'd120;
  localparam int         FB_DEPTH = 19200;
  localparam int         FB_AW    = 15;
  localparam int         COLOUR_W = 3;

  // Default 640x480@60 timing, in pixel slots and lines.
  localparam int         VGA_CLK_DIV = 2;
  localparam logic [9:0] VGA_H_VIS   = 10'd640;
  localparam logic [9:0] VGA_H_FP    = 10'd16;
  localparam logic [9:0] VGA_H_SYNC  = 10'd96;
  localparam logic [9:0] VGA_H_BP    = 10'd48;
  localparam logic [9:0] VGA_V_VIS   = 10'd480;
  localparam logic [9:0] VGA_V_FP    = 10'd10;
  localparam logic [9:0] VGA_V_SYNC  = 10'd2;
  localparam logic [9:0] VGA_V_BP    = 10'd33;

  typedef logic [COLOUR_W-1:0] pixel_t;

  // Timing bundle that travels down the pipeline beside the RAM data.
  typedef struct packed {
    logic hs;   // active low
    logic vs;   // active low
    logic vis;  // inside the visible area
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // row*160 + col built from two shifts and adds; no multiplier.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] row,
                                               input logic [7:0] col);
    logic [FB_AW-1:0] r;
    r = {7'b0, row};
    return (r << 7) + (r << 5) + {7'b0, col};
  endfunction

  // Each colour bit becomes a full-scale or zero DAC byte, packed {R,G,B}.
  function automatic logic [23:0] expand_colour(input pixel_t c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

endpackage

// File: rtl/vga_scanout_fb_ram.sv
// Simple dual-port framebuffer RAM, 19200 x 3, registered read data.
// Read-during-write to one address returns the previous contents.
module vga_scanout_fb_ram
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [FB_AW-1:0] waddr_i,
  input  pixel_t           wdata_i,
  input  logic             re_i,
  input  logic [FB_AW-1:0] raddr_i,
  output pixel_t           rdata_o
);

  pixel_t mem_q [FB_DEPTH];

  // NOTE: storage and read register have no reset so the array maps onto block RAM; picture content must survive reset anyway.
  // Write port and registered read port; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: accepts pixel plots into a 160x120 framebuffer and
// streams it as 640x480 video, each stored pixel covering a 4x4 block.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int         CLK_DIV = VGA_CLK_DIV,
  parameter logic [9:0] H_VIS   = VGA_H_VIS,
  parameter logic [9:0] H_FP    = VGA_H_FP,
  parameter logic [9:0] H_SYNC  = VGA_H_SYNC,
  parameter logic [9:0] H_BP    = VGA_H_BP,
  parameter logic [9:0] V_VIS   = VGA_V_VIS,
  parameter logic [9:0] V_FP    = VGA_V_FP,
  parameter logic [9:0] V_SYNC  = VGA_V_SYNC,
  parameter logic [9:0] V_BP    = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam logic [9:0] H_MAX     = H_VIS + H_FP + H_SYNC + H_BP - 10'd1;
  localparam logic [9:0] V_MAX     = V_VIS + V_FP + V_SYNC + V_BP - 10'd1;
  localparam logic [9:0] H_SYNC_LO = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_HI = H_VIS + H_FP + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_LO = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_HI = V_VIS + V_FP + V_SYNC - 10'd1;
  localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             fs_q, fs_d;
  sync_t            sync_0, sync_1_q, sync_2_q;
  logic [23:0]      rgb_q, rgb_d;
  logic [FB_AW-1:0] raddr;
  logic             we;
  logic [FB_AW-1:0] waddr;
  pixel_t           rdata;

  // Pixel slot strobe: one clk in every CLK_DIV.
  assign pix_en = (div_q == DIV_MAX);

  // Next divider and scan position; counters only move on pix_en.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    div_d = pix_en ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    fs_d  = 1'b0;
    if (pix_en) begin
      if (h_q == H_MAX) begin
        h_d  = '0;
        v_d  = (v_q == V_MAX) ? '0 : v_q + 10'd1;
        fs_d = (v_q == V_MAX);
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // NOTE: clocked state is written with <= only, so every flop samples pre-edge values regardless of block order.
  // Divider, scan counters and the frame marker register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fs_q  <= fs_d;
    end
  end

  // Stage 0: sync/visible decode and read address from the live counters.
  always_comb begin
    sync_0.hs  = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
    sync_0.vs  = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
    sync_0.vis = (h_q < H_VIS) && (v_q < V_VIS);
    raddr      = fb_addr(v_q[9:2], h_q[9:2]);
  end

  // Plot port: always live, out-of-range coordinates dropped.
  always_comb begin
    we    = plot && (x < FB_W) && (y < FB_H);
    waddr = fb_addr({1'b0, y}, x);
  end

  vga_scanout_fb_ram u_fb_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (colour),
    .re_i    (pix_en),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Stage 2 colour: expand RAM data, black outside the visible area.
  always_comb begin
    rgb_d = sync_1_q.vis ? expand_colour(rdata) : 24'h0;
  end

  // Stages 1 and 2: sync bundle delayed two slots to line up with RAM data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1_q <= SYNC_IDLE;
      sync_2_q <= SYNC_IDLE;
      rgb_q    <= '0;
    end else if (pix_en) begin
      sync_1_q <= sync_0;
      sync_2_q <= sync_1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = sync_2_q.hs;
  assign vga_vs      = sync_2_q.vs;
  assign vga_blank_n = sync_2_q.vis;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = pix_en;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster (48x22 slots,
// 32x16 visible) so several whole frames fit in a short run.
module tb_vga_scanout;

  localparam int HV  = 32;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VV  = 16;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  // {rgb, hs, vs, blank_n, sync_n} while idle or in reset.
  localparam logic [27:0] IDLE = {24'h0, 4'b1100};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  vga_scanout #(
    .CLK_DIV (2),
    .H_VIS   (10'(HV)),  .H_FP (10'(HFP)), .H_SYNC (10'(HS)), .H_BP (10'(HBP)),
    .V_VIS   (10'(VV)),  .V_FP (10'(VFP)), .V_SYNC (10'(VS)), .V_BP (10'(VBP))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [2:0]  shadow [19200];
  logic [27:0] sb [$];
  int unsigned k = 0;
  logic        pend_plot = 1'b0;
  logic [7:0]  pend_x = '0;
  logic [6:0]  pend_y = '0;
  logic [2:0]  pend_c = '0;
  logic [27:0] obs_v, exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output word for raster slot s, from the shadow framebuffer.
  function automatic logic [27:0] exp_slot(input int unsigned s);
    int unsigned h, v;
    logic hs_e, vs_e, vis_e;
    logic [2:0] c;
    h     = s % HT;
    v     = (s / HT) % VT;
    hs_e  = !((h >= HV + HFP) && (h < HV + HFP + HS));
    vs_e  = !((v >= VV + VFP) && (v < VV + VFP + VS));
    vis_e = (h < HV) && (v < VV);
    c     = vis_e ? shadow[(v / 4) * 160 + (h / 4)] : 3'b000;
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs_e, vs_e, vis_e, 1'b0};
  endfunction

  // Monitor: push expected slot when the DUT reads it, pop two slots later.
  always @(negedge clk) begin
    obs_v = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n};
    if (!reset) begin
      k = 0;
      sb.delete();
      check("reset_video", 32'(obs_v), 32'(IDLE));
      check("reset_frame_start", 32'(frame_start), 32'd0);
      check("reset_vga_clk", 32'(vga_clk), 32'd0);
    end else begin
      k++;
      check("vga_clk", 32'(vga_clk), 32'(k % 2 == 1));
      check("frame_start", 32'(frame_start), 32'((k % 2 == 0) && ((k / 2) % FRAME == 0)));
      if (k % 2 == 0) begin
        sb.push_back(exp_slot(k / 2 - 1));
        if (k / 2 < 2) begin
          check("pipe_fill", 32'(obs_v), 32'(IDLE));
        end else begin
          exp_v = sb.pop_front();
          check("video", 32'(obs_v), 32'(exp_v));
        end
      end
    end
    // Apply the write taken on the edge just passed, after the read above.
    if (pend_plot && pend_x < 8'd160 && pend_y < 7'd120)
      shadow[int'(pend_y) * 160 + int'(pend_x)] = pend_c;
    pend_plot = plot;
    pend_x    = x;
    pend_y    = y;
    pend_c    = colour;
  end

  task automatic drive_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    @(posedge clk); #1;
    x = px; y = py; colour = pc; plot = 1'b1;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    plot = 1'b0;
  endtask

  task automatic sweep(input logic [2:0] pc);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        drive_plot(8'(xx), 7'(yy), pc);
    idle_bus();
  endtask

  // Wait for frame_start; n returns the clk count it took.
  task automatic wait_fs(input string tag, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 6 * FRAME) begin
      @(posedge clk); #1;
      n++;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic release_and_time_hs(input string tag);
    int n;
    @(negedge clk); #1 reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vga_hs !== 1'b0 && n < 4 * FRAME);
    check(tag, 32'(n), 32'(2 * (HV + HFP + 2)));
  endtask

  initial begin
    int n;
    reset = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
    repeat (4) @(posedge clk);

    // White fill, then black sweep, both while reset is low.
    sweep(3'b111);
    sweep(3'b000);

    // Release: scan starts at (0,0); hs falls at the front-porch end.
    release_and_time_hs("hs_first_low");

    // Plot during vertical blanking of the next frame.
    wait_fs("wait_fs_1", n);
    repeat (2 * HT * VV + 4) @(posedge clk);
    drive_plot(8'd0,   7'd0,   3'b010);
    drive_plot(8'd7,   7'd3,   3'b111);
    drive_plot(8'd160, 7'd0,   3'b100);
    drive_plot(8'd0,   7'd120, 3'b100);
    drive_plot(8'd200, 7'd3,   3'b100);
    drive_plot(8'd159, 7'd119, 3'b111);
    idle_bus();
    wait_fs("wait_fs_2", n);
    wait_fs("wait_fs_3", n);

    // Write (1,1) on the very edge that reads its last screen slot.
    repeat (2 * (7 * HT + 7 + 1) - 1) @(posedge clk);
    #1; x = 8'd1; y = 7'd1; colour = 3'b001; plot = 1'b1;
    idle_bus();
    wait_fs("wait_fs_4", n);
    wait_fs("fs_period_wait", n);
    check("fs_period", 32'(n), 32'(2 * FRAME));

    // Reset pulse mid-frame: scan restarts from (0,0), content kept.
    repeat (500) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    release_and_time_hs("hs_after_rereset");
    wait_fs("wait_fs_5", n);
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
